// File: rtl/decode_stage.sv
// decode_stage: RV32 decode of one pc/instruction per cycle into a DEPTH-entry FIFO,
// with an explicit illegal flag, a saturating illegal counter and synchronous flush.
package tartaruga_pkg;
  typedef logic [31:0] bus32_t;
  typedef logic [31:0] instruction_t;
  typedef logic [4:0] reg_addr_t;
  localparam logic [6:0] OP_ALU_I = 7'b0010011;
  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] F7_ALU_NORMAL = 7'b0000000;
  localparam logic [6:0] F7_ALU_MODIFIED = 7'b0100000;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;
  typedef enum logic {SRC1_RS1, SRC1_PC} src1_t;
  typedef enum logic {SRC2_RS2, SRC2_IMM} src2_t;
  typedef enum logic {WB_ALU, WB_MEM} wb_t;
  typedef struct packed {
    bus32_t pc;
    instruction_t instr;
    reg_addr_t addr_rs1;
    reg_addr_t addr_rs2;
    reg_addr_t addr_rd;
    logic write_enable;
    src1_t src1;
    src2_t src2;
    alu_op_t alu_op;
    wb_t alu_or_mem;
    logic store_to_mem;
  } instr_data_t;
endpackage

module decode_stage import tartaruga_pkg::*; #(
  parameter int DEPTH = 2,
  parameter bit MEM_EN = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  bus32_t           pc_i,
  input  instruction_t     instr_i,
  output logic             valid_o,
  input  logic             ready_i,
  output instr_data_t      instr_decoded_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  function automatic alu_op_t base_op(input logic [2:0] f);
    case (f)
      3'b000: return ALU_ADD;
      3'b001: return ALU_SLL;
      3'b010: return ALU_SLT;
      3'b011: return ALU_SLTU;
      3'b100: return ALU_XOR;
      3'b101: return ALU_SRL;
      3'b110: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0] op, f7;
  logic [2:0] f3;
  logic ill;
  instr_data_t raw, nop, dec;

  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];

  always_comb begin
    raw = '0;
    raw.pc = pc_i;
    raw.instr = instr_i;
    raw.addr_rs1 = instr_i[19:15];
    raw.addr_rs2 = instr_i[24:20];
    raw.addr_rd = instr_i[11:7];
    raw.alu_op = base_op(f3);
    ill = 1'b0;
    case (op)
      OP_ALU_I: begin
        raw.write_enable = 1'b1;
        raw.src2 = SRC2_IMM;
        if (f3 == F3_SLL) ill = f7 != F7_ALU_NORMAL;
        if (f3 == F3_SRL_SRA) begin
          ill = f7 != F7_ALU_NORMAL && f7 != F7_ALU_MODIFIED;
          raw.alu_op = f7 == F7_ALU_MODIFIED ? ALU_SRA : ALU_SRL;
        end
      end
      OP_ALU: begin
        raw.write_enable = 1'b1;
        if (f7 == F7_ALU_MODIFIED) begin
          ill = f3 != F3_ADD_SUB && f3 != F3_SRL_SRA;
          raw.alu_op = f3 == F3_ADD_SUB ? ALU_SUB : ALU_SRA;
        end else ill = f7 != F7_ALU_NORMAL;
      end
      OP_LUI: begin
        raw.write_enable = 1'b1;
        raw.addr_rs1 = '0;
        raw.src2 = SRC2_IMM;
        raw.alu_op = ALU_ADD;
      end
      OP_AUIPC: begin
        raw.write_enable = 1'b1;
        raw.src1 = SRC1_PC;
        raw.src2 = SRC2_IMM;
        raw.alu_op = ALU_ADD;
      end
      OP_LOAD: begin
        raw.write_enable = 1'b1;
        raw.src2 = SRC2_IMM;
        raw.alu_op = ALU_ADD;
        raw.alu_or_mem = WB_MEM;
        ill = !MEM_EN || f3 inside {3'b011, 3'b110, 3'b111};
      end
      OP_STORE: begin
        raw.src2 = SRC2_IMM;
        raw.alu_op = ALU_ADD;
        raw.store_to_mem = 1'b1;
        raw.addr_rd = '0;
        ill = !MEM_EN || f3[2] || f3 == 3'b011;
      end
      default: ill = 1'b1;
    endcase
  end

  // illegal encodings collapse to a NOP that still carries pc/instr for trap handling
  always_comb begin
    nop = '0;
    nop.pc = pc_i;
    nop.instr = instr_i;
  end

  assign dec = ill ? nop : raw;

  instr_data_t mem_q [DEPTH];
  logic ill_mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic push, pop;

  assign ready_o = cnt_q < CW'(DEPTH);
  assign valid_o = cnt_q != '0;
  assign push = valid_i && ready_o && !flush_i;
  assign pop = valid_o && ready_i && !flush_i;

  always_comb begin
    wr_d = flush_i ? '0 : wr_q + AW'(push);
    rd_d = flush_i ? '0 : rd_q + AW'(pop);
    cnt_d = flush_i ? '0 : cnt_q + CW'(push) - CW'(pop);
    icnt_d = push && ill && !(&icnt_q) ? icnt_q + 1'b1 : icnt_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      icnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      icnt_q <= icnt_d;
    end
  end

  // payload needs no reset: it is only visible through the count-gated outputs
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_q] <= dec;
      ill_mem_q[wr_q] <= ill;
    end
  end

  assign instr_decoded_o = valid_o ? mem_q[rd_q] : '0;
  assign illegal_o = valid_o && ill_mem_q[rd_q];
  assign illegal_cnt_o = icnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: random and directed stimulus against a queue-based decode model,
// two DUTs in lockstep (MEM_EN=1/CNT_W=16 and MEM_EN=0/CNT_W=2).
module tb_decode_stage;
  import tartaruga_pkg::*;
  localparam int DEPTH = 4;
  localparam alu_op_t BASE [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

  logic clk = 1'b0;
  logic rstn, flush_i, valid_i, ready_i;
  logic [31:0] pc_i, instr_i;
  logic valid_a, ready_a, ill_a, valid_b, ready_b, ill_b;
  instr_data_t dec_a, dec_b;
  logic [15:0] cnt_a_o;
  logic [1:0] cnt_b_o;

  int total = 0, bad = 0;
  logic [63:0] q[$];
  int cnt_a = 0, cnt_b = 0;
  logic [31:0] pc = 32'h1000;

  always #5 clk = ~clk;

  decode_stage #(.DEPTH(DEPTH), .MEM_EN(1'b1), .CNT_W(16)) u_a (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_a),
    .pc_i(pc_i), .instr_i(instr_i), .valid_o(valid_a), .ready_i(ready_i),
    .instr_decoded_o(dec_a), .illegal_o(ill_a), .illegal_cnt_o(cnt_a_o));

  decode_stage #(.DEPTH(DEPTH), .MEM_EN(1'b0), .CNT_W(2)) u_b (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_b),
    .pc_i(pc_i), .instr_i(instr_i), .valid_o(valid_b), .ready_i(ready_i),
    .instr_decoded_o(dec_b), .illegal_o(ill_b), .illegal_cnt_o(cnt_b_o));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic void ref_decode(input logic [63:0] e, input bit mem_en,
                                     output instr_data_t d, output bit ill);
    logic [31:0] ins;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit imm, alt, f7_ok;
    ins = e[31:0];
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    d = '0;
    d.pc = e[63:32];
    d.instr = ins;
    d.addr_rs1 = ins[19:15];
    d.addr_rs2 = ins[24:20];
    d.addr_rd = ins[11:7];
    ill = 1'b0;
    if (op == OP_ALU_I || op == OP_ALU) begin
      imm = op == OP_ALU_I;
      alt = f7 == 7'h20;
      f7_ok = f7 == 7'h00 || (alt && (f3 == 3'd5 || (!imm && f3 == 3'd0)));
      ill = !(f7_ok || (imm && f3 != 3'd1 && f3 != 3'd5));
      d.write_enable = 1'b1;
      d.src2 = imm ? SRC2_IMM : SRC2_RS2;
      d.alu_op = (alt && f7_ok) ? (f3 == 3'd0 ? ALU_SUB : ALU_SRA) : BASE[f3];
    end else if (op == OP_LUI) begin
      d.write_enable = 1'b1;
      d.addr_rs1 = '0;
      d.src2 = SRC2_IMM;
    end else if (op == OP_AUIPC) begin
      d.write_enable = 1'b1;
      d.src1 = SRC1_PC;
      d.src2 = SRC2_IMM;
    end else if (op == OP_LOAD) begin
      ill = !mem_en || !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      d.write_enable = 1'b1;
      d.src2 = SRC2_IMM;
      d.alu_or_mem = WB_MEM;
    end else if (op == OP_STORE) begin
      ill = !mem_en || f3 > 3'd2;
      d.src2 = SRC2_IMM;
      d.store_to_mem = 1'b1;
      d.addr_rd = '0;
    end else ill = 1'b1;
    if (ill) begin
      d = '0;
      d.pc = e[63:32];
      d.instr = ins;
    end
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0] ops [6] = '{OP_ALU_I, OP_ALU, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE};
    int k, s;
    ins = $urandom;
    k = $urandom_range(0, 6);
    if (k < 6) ins[6:0] = ops[k];
    s = $urandom_range(0, 2);
    if (s == 0) ins[31:25] = 7'h00;
    if (s == 1) ins[31:25] = 7'h20;
    return ins;
  endfunction

  task automatic compare_all();
    instr_data_t ea, eb;
    bit ia, ib;
    ea = '0;
    eb = '0;
    ia = 1'b0;
    ib = 1'b0;
    if (q.size() != 0) begin
      ref_decode(q[0], 1'b1, ea, ia);
      ref_decode(q[0], 1'b0, eb, ib);
    end
    check("valid_a", valid_a, q.size() != 0);
    check("ready_a", ready_a, q.size() < DEPTH);
    check("dec_a", dec_a, ea);
    check("ill_a", ill_a, ia);
    check("cnt_a", cnt_a_o, cnt_a);
    check("valid_b", valid_b, q.size() != 0);
    check("ready_b", ready_b, q.size() < DEPTH);
    check("dec_b", dec_b, eb);
    check("ill_b", ill_b, ib);
    check("cnt_b", cnt_b_o, cnt_b);
  endtask

  task automatic cycle(input logic v, input logic [31:0] ins, input logic r, input logic f);
    logic [63:0] e;
    bit push, pop, ba, bb;
    instr_data_t dd;
    valid_i = v;
    instr_i = ins;
    pc_i = pc;
    ready_i = r;
    flush_i = f;
    e = {pc, ins};
    pc += 32'd4;
    push = v && q.size() < DEPTH && !f;
    pop = q.size() != 0 && r && !f;
    if (push) begin
      ref_decode(e, 1'b1, dd, ba);
      ref_decode(e, 1'b0, dd, bb);
      if (ba && cnt_a < 65535) cnt_a++;
      if (bb && cnt_b < 3) cnt_b++;
    end
    if (f) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int acc, c0;
    rstn = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    pc_i = '0;
    instr_i = '0;
    repeat (2) @(negedge clk);
    compare_all();
    rstn = 1'b1;
    @(negedge clk);
    compare_all();
    cycle(1'b1, 32'h00500093, 1'b1, 1'b0);
    check("addi_op", dec_a.alu_op, ALU_ADD);
    check("addi_src2", dec_a.src2, SRC2_IMM);
    check("addi_rd", dec_a.addr_rd, 5'd1);
    check("addi_we", dec_a.write_enable, 1'b1);
    check("addi_ill", ill_a, 1'b0);
    cycle(1'b1, 32'h402081B3, 1'b1, 1'b0);
    check("sub_op", dec_a.alu_op, ALU_SUB);
    check("sub_rd", dec_a.addr_rd, 5'd3);
    cycle(1'b1, 32'h00812283, 1'b1, 1'b0);
    check("lw_wb", dec_a.alu_or_mem, WB_MEM);
    check("lw_rd", dec_a.addr_rd, 5'd5);
    check("lw_ill_nomem", ill_b, 1'b1);
    cycle(1'b1, 32'h00512623, 1'b1, 1'b0);
    check("sw_store", dec_a.store_to_mem, 1'b1);
    check("sw_rd", dec_a.addr_rd, 5'd0);
    cycle(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    check("ones_ill", ill_a, 1'b1);
    check("ones_we", dec_a.write_enable, 1'b0);
    cycle(1'b1, 32'h40109093, 1'b1, 1'b0);
    check("slli_ill", ill_a, 1'b1);
    check("slli_addr", {dec_a.addr_rs1, dec_a.addr_rs2, dec_a.addr_rd}, 15'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("ill_cnt2", cnt_a_o, 16'd2);
    for (int rep = 0; rep < 3; rep++) begin
      acc = 0;
      for (int i = 0; i < DEPTH + 2; i++) begin
        acc += int'(ready_a);
        cycle(1'b1, rand_instr(), 1'b0, 1'b0);
      end
      check("bp_accepts", acc, DEPTH);
      check("bp_ready", ready_a, 1'b0);
      for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    end
    cycle(1'b1, 32'h00500093, 1'b0, 1'b0);
    cycle(1'b1, 32'h00812283, 1'b0, 1'b0);
    c0 = cnt_a;
    cycle(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
    check("flush_valid", valid_a, 1'b0);
    check("flush_ready", ready_a, 1'b1);
    check("flush_cnt", cnt_a_o, c0);
    cycle(1'b1, 32'h00500093, 1'b0, 1'b0);
    cycle(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    valid_i = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("rst_valid", valid_a, 1'b0);
    check("rst_ready", ready_a, 1'b1);
    check("rst_dec", dec_a, 128'd0);
    check("rst_ill", ill_a, 1'b0);
    check("rst_cnt_a", cnt_a_o, 16'd0);
    check("rst_cnt_b", cnt_b_o, 2'd0);
    q.delete();
    cnt_a = 0;
    cnt_b = 0;
    @(negedge clk);
    rstn = 1'b1;
    compare_all();
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    check("sat_b", cnt_b_o, 2'd3);
    check("cnt_a5", cnt_a_o, 16'd5);
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
